// File: rtl/fir_stream_controller.sv
`default_nettype none
// ============================================================================
// Module      : fir_stream_controller
// Description : AHB-lite manager for the ahb_fir_filter subordinate. It loads
//               the four filter coefficients on request. It then streams
//               samples from a valid/ready input through the filter and
//               returns each result on a valid/ready output. Filter status is
//               polled between transfers. Bus errors and poll timeouts park
//               the block in a sticky error state.
// Ports       : clk, n_rst (sync, active-low)
//               cfg_start, coeff0..3, cfg_done      - coefficient load
//               sample_valid/ready/data             - input stream
//               result_valid/ready/data             - output stream
//               busy, error, err_clr                - status / recovery
//               hsel, hwrite, hsize, htrans, haddr,
//               hwdata, hrdata, hresp               - AHB-lite manager
// Revision    : 1.0 - initial release
// ============================================================================
module fir_stream_controller #(
    parameter int POLL_LIMIT     = 64,
    parameter int CFG_POLL_LIMIT = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cfg_start,
    input  logic [15:0] coeff0,
    input  logic [15:0] coeff1,
    input  logic [15:0] coeff2,
    input  logic [15:0] coeff3,
    output logic        cfg_done,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [15:0] sample_data,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [15:0] result_data,
    output logic        busy,
    output logic        error,
    input  logic        err_clr,
    output logic        hsel,
    output logic        hwrite,
    output logic        hsize,
    output logic [1:0]  htrans,
    output logic [3:0]  haddr,
    output logic [15:0] hwdata,
    input  logic [15:0] hrdata,
    input  logic        hresp
);

    localparam int c_max_limit = (POLL_LIMIT > CFG_POLL_LIMIT) ? POLL_LIMIT : CFG_POLL_LIMIT;
    localparam int c_cnt_w     = $clog2(c_max_limit) + 1;
    localparam logic [c_cnt_w-1:0] c_poll_lim     = POLL_LIMIT[c_cnt_w-1:0];
    localparam logic [c_cnt_w-1:0] c_cfg_poll_lim = CFG_POLL_LIMIT[c_cnt_w-1:0];

    localparam logic [3:0] c_st_idle        = 4'd0;
    localparam logic [3:0] c_st_cfg_wr      = 4'd1;
    localparam logic [3:0] c_st_cfg_poll    = 4'd2;
    localparam logic [3:0] c_st_stream_wait = 4'd3;
    localparam logic [3:0] c_st_pre_poll    = 4'd4;
    localparam logic [3:0] c_st_smp_wr      = 4'd5;
    localparam logic [3:0] c_st_post_poll   = 4'd6;
    localparam logic [3:0] c_st_res_rd      = 4'd7;
    localparam logic [3:0] c_st_res_out     = 4'd8;
    localparam logic [3:0] c_st_error       = 4'd9;

    logic [3:0]         r_state;
    logic [3:0]         w_state_nxt;
    logic               r_phase;        // 0: address phase, 1: data phase
    logic [2:0]         r_idx;          // CFG_WR transfer index, 4 = load-control write
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic [15:0]        r_coef [4];
    logic [15:0]        r_sample;
    logic [15:0]        r_result;
    logic               r_cfg_done;

    logic               w_bus;
    logic               w_dphase;
    logic               w_rd_zero;
    logic               w_is_write;
    logic [3:0]         w_addr;
    logic [15:0]        w_wdata;
    logic               w_cfg_accept;
    logic               w_smp_accept;

    // The "configured" condition is carried by the state itself: STREAM_WAIT
    // and the streaming states are reachable only through a completed load,
    // and err_clr always lands in IDLE.
    assign w_bus = (r_state == c_st_cfg_wr)    || (r_state == c_st_cfg_poll) ||
                   (r_state == c_st_pre_poll)  || (r_state == c_st_smp_wr)   ||
                   (r_state == c_st_post_poll) || (r_state == c_st_res_rd);
    assign w_dphase     = w_bus && r_phase;
    assign w_rd_zero    = (hrdata == 16'h0000);
    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_cfg_accept = cfg_start && ((r_state == c_st_idle) || (r_state == c_st_stream_wait));
    assign w_smp_accept = (r_state == c_st_stream_wait) && !cfg_start && sample_valid;

    // Per-state transfer attributes
    always_comb begin
        w_addr     = 4'h0;
        w_wdata    = 16'h0000;
        w_is_write = 1'b0;
        case (r_state)
            c_st_cfg_wr: begin
                // 0x6 + 2*idx walks F0..F3 and lands on 0xE for idx = 4
                w_addr     = 4'h6 + {r_idx, 1'b0};
                w_wdata    = (r_idx[2]) ? 16'h0001 : r_coef[r_idx[1:0]];
                w_is_write = 1'b1;
            end
            c_st_cfg_poll: w_addr = 4'hE;
            c_st_smp_wr: begin
                w_addr     = 4'h4;
                w_wdata    = r_sample;
                w_is_write = 1'b1;
            end
            c_st_res_rd: w_addr = 4'h2;
            default: w_addr = 4'h0;
        endcase
    end

    // AHB and stream outputs
    always_comb begin
        hsel         = w_bus && !r_phase;
        htrans       = {hsel, 1'b0};
        hsize        = hsel;
        hwrite       = hsel && w_is_write;
        haddr        = hsel ? w_addr : 4'h0;
        hwdata       = (w_dphase && w_is_write) ? w_wdata : 16'h0000;
        sample_ready = (r_state == c_st_stream_wait) && !cfg_start;
        result_valid = (r_state == c_st_res_out);
        result_data  = r_result;
        busy         = w_bus || (r_state == c_st_res_out);
        error        = (r_state == c_st_error);
        cfg_done     = r_cfg_done;
    end

    // Next-state logic; bus states only move at the end of a data phase
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:
                if (cfg_start) w_state_nxt = c_st_cfg_wr;
            c_st_cfg_wr:
                if (w_dphase) begin
                    if (hresp)              w_state_nxt = c_st_error;
                    else if (r_idx == 3'd4) w_state_nxt = c_st_cfg_poll;
                end
            c_st_cfg_poll:
                if (w_dphase) begin
                    if (hresp)                            w_state_nxt = c_st_error;
                    else if (w_rd_zero)                   w_state_nxt = c_st_stream_wait;
                    else if (w_cnt_inc >= c_cfg_poll_lim) w_state_nxt = c_st_error;
                end
            c_st_stream_wait:
                if (cfg_start)         w_state_nxt = c_st_cfg_wr;
                else if (sample_valid) w_state_nxt = c_st_pre_poll;
            c_st_pre_poll:
                if (w_dphase) begin
                    if (hresp)                        w_state_nxt = c_st_error;
                    else if (w_rd_zero)               w_state_nxt = c_st_smp_wr;
                    else if (w_cnt_inc >= c_poll_lim) w_state_nxt = c_st_error;
                end
            c_st_smp_wr:
                if (w_dphase) w_state_nxt = hresp ? c_st_error : c_st_post_poll;
            c_st_post_poll:
                if (w_dphase) begin
                    if (hresp)                        w_state_nxt = c_st_error;
                    else if (w_rd_zero)               w_state_nxt = c_st_res_rd;
                    else if (w_cnt_inc >= c_poll_lim) w_state_nxt = c_st_error;
                end
            c_st_res_rd:
                if (w_dphase) w_state_nxt = hresp ? c_st_error : c_st_res_out;
            c_st_res_out:
                if (result_ready) w_state_nxt = c_st_stream_wait;
            c_st_error:
                if (err_clr) w_state_nxt = c_st_idle;
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_phase    <= 1'b0;
            r_idx      <= 3'd0;
            r_cnt      <= '0;
            r_coef[0]  <= 16'h0000;
            r_coef[1]  <= 16'h0000;
            r_coef[2]  <= 16'h0000;
            r_coef[3]  <= 16'h0000;
            r_sample   <= 16'h0000;
            r_result   <= 16'h0000;
            r_cfg_done <= 1'b0;
        end else begin
            // Every state change out of a bus state happens at the end of a
            // data phase, so toggling here always restarts at an address phase.
            r_phase    <= w_bus ? !r_phase : 1'b0;
            r_cfg_done <= (r_state == c_st_cfg_poll) && (w_state_nxt == c_st_stream_wait);

            if (w_cfg_accept) begin
                r_coef[0] <= coeff0;
                r_coef[1] <= coeff1;
                r_coef[2] <= coeff2;
                r_coef[3] <= coeff3;
                r_idx     <= 3'd0;
            end else if ((r_state == c_st_cfg_wr) && w_dphase && !hresp && (r_idx != 3'd4)) begin
                r_idx <= r_idx + 3'd1;
            end

            // Any state change starts a fresh poll sequence
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (w_dphase)          r_cnt <= w_cnt_inc;

            if (w_smp_accept) r_sample <= sample_data;

            if ((r_state == c_st_res_rd) && w_dphase && !hresp) r_result <= hrdata;
        end
    end

endmodule
`default_nettype wire
